// File: rtl/tagged_dir_queue_mc_pkg.sv
// Shared types for the tagged direction queue.
//   TaggedDirection : ray direction (three 32-bit components) plus a tag of
//                     `TAG_SIZE bits. `TAG_SIZE defaults to 8 when the build
//                     does not define it.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

package tagged_dir_queue_mc_pkg;

  localparam int TAG_SIZE = `TAG_SIZE;

  typedef struct packed {
    logic [31:0]         dir_x;
    logic [31:0]         dir_y;
    logic [31:0]         dir_z;
    logic [TAG_SIZE-1:0] tag;
  } TaggedDirection;

endpackage

// File: rtl/tagged_dir_ch_fifo.sv
// One producer channel of the tagged direction queue: a circular buffer of
// DEPTH entries, with pointers, occupancy and flow-control flags.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push_valid/data   : push request; dropped when the buffer is full
//   pop               : consume the head entry (ignored when empty)
//   head, nonempty    : current head entry and its validity
//   in_ready          : buffer not full (depends on registered state only)
//   almost_full       : count >= AFULL_LVL
//   count             : occupancy
//   overflow          : registered one-cycle pulse after a dropped push
//   drop_cnt, hwm     : saturating drop counter and occupancy high-water mark,
//                       present only when TAGGED_DIR_QUEUE_STATS_EN is defined
module tagged_dir_ch_fifo
  import tagged_dir_queue_mc_pkg::*;
#(
  parameter int  DEPTH     = 16,
  parameter int  AFULL_LVL = DEPTH - 2,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push_valid,
  input  TaggedDirection push_data,
  input  logic           pop,
  output TaggedDirection head,
  output logic           nonempty,
  output logic           in_ready,
  output logic           almost_full,
  output logic [CW-1:0]  count,
  output logic           overflow
`ifdef TAGGED_DIR_QUEUE_STATS_EN
  ,
  output logic [15:0]    drop_cnt,
  output logic [CW-1:0]  hwm
`endif
);

  TaggedDirection mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, drop, pop_ok;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign nonempty    = (count_q != '0);
  assign almost_full = (count_q >= CW'(AFULL_LVL));
  assign push        = push_valid && in_ready;
  assign drop        = push_valid && !in_ready;
  assign pop_ok      = pop && nonempty;
  assign head        = mem[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = overflow_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = drop;
    if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the buffer array has no reset; count gates every read, so stale
  // contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

`ifdef TAGGED_DIR_QUEUE_STATS_EN
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      hwm_q      <= hwm_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign hwm      = hwm_q;
`endif

endmodule

// File: rtl/tagged_dir_queue_mc.sv
// Multi-channel TaggedDirection queue. NUM_CH producer channels each own a
// DEPTH-entry circular buffer; a round-robin arbiter moves one head entry per
// cycle into a registered valid/ready output stream tagged with its channel.
// Optional feature macro: TAGGED_DIR_QUEUE_STATS_EN (adds drop_cnt and hwm).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid, in_dir      : per-channel push request and data
//   in_ready              : per-channel not-full (no path from out_ready)
//   almost_full, count    : per-channel occupancy status
//   overflow              : per-channel one-cycle pulse after a dropped push
//   out_valid/dir/ch      : output register contents and source channel
//   out_ready             : consumer accept
//   drop_cnt, hwm         : per-channel statistics (stats build only)
module tagged_dir_queue_mc
  import tagged_dir_queue_mc_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  DEPTH     = 16,
  parameter int  AFULL_LVL = DEPTH - 2,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic           [NUM_CH-1:0]  in_valid,
  input  TaggedDirection [NUM_CH-1:0]  in_dir,
  output logic           [NUM_CH-1:0]  in_ready,
  output logic           [NUM_CH-1:0]  almost_full,
  output logic [NUM_CH-1:0][CW-1:0]    count,
  output logic           [NUM_CH-1:0]  overflow,
  output logic                         out_valid,
  output TaggedDirection               out_dir,
  output logic           [CHW-1:0]     out_ch,
  input  logic                         out_ready
`ifdef TAGGED_DIR_QUEUE_STATS_EN
  ,
  output logic [NUM_CH-1:0][15:0]      drop_cnt,
  output logic [NUM_CH-1:0][CW-1:0]    hwm
`endif
);

  TaggedDirection [NUM_CH-1:0] head;
  logic           [NUM_CH-1:0] nonempty;
  logic           [NUM_CH-1:0] pop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tagged_dir_ch_fifo #(
      .DEPTH     (DEPTH),
      .AFULL_LVL (AFULL_LVL)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (in_valid[c]),
      .push_data   (in_dir[c]),
      .pop         (pop[c]),
      .head        (head[c]),
      .nonempty    (nonempty[c]),
      .in_ready    (in_ready[c]),
      .almost_full (almost_full[c]),
      .count       (count[c]),
      .overflow    (overflow[c])
`ifdef TAGGED_DIR_QUEUE_STATS_EN
      ,
      .drop_cnt    (drop_cnt[c]),
      .hwm         (hwm[c])
`endif
    );
  end

  logic           out_valid_q, out_valid_d;
  TaggedDirection out_dir_q, out_dir_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic [CHW-1:0] last_grant_q, last_grant_d;
  logic           load, grant_found;
  logic [CHW-1:0] grant_idx, cand;

  // The output register may take a new entry when it is empty or its
  // current entry is being accepted this cycle.
  assign load = !out_valid_q || out_ready;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CHW'((int'(last_grant_q) + 1 + i) % NUM_CH);
      if (!grant_found && nonempty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pop          = '0;
    out_valid_d  = out_valid_q;
    out_dir_d    = out_dir_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        pop[grant_idx] = 1'b1;
        out_dir_d      = head[grant_idx];
        out_ch_d       = grant_idx;
        last_grant_d   = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_dir_q    <= '0;
      out_ch_q     <= '0;
      last_grant_q <= CHW'(NUM_CH - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_dir_q    <= out_dir_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dir   = out_dir_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_tagged_dir_queue_mc.sv
// Self-checking bench for tagged_dir_queue_mc. A queue-based reference model
// tracks per-channel FIFOs, the output register and the round-robin pointer.
module tb_tagged_dir_queue_mc;
  import tagged_dir_queue_mc_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_LVL = DEPTH - 2;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int CHW       = 2;

  logic                         clk = 1'b0;
  logic                         reset;
  logic           [NUM_CH-1:0]  in_valid;
  TaggedDirection [NUM_CH-1:0]  in_dir;
  logic           [NUM_CH-1:0]  in_ready;
  logic           [NUM_CH-1:0]  almost_full;
  logic [NUM_CH-1:0][CW-1:0]    count;
  logic           [NUM_CH-1:0]  overflow;
  logic                         out_valid;
  TaggedDirection               out_dir;
  logic           [CHW-1:0]     out_ch;
  logic                         out_ready;
`ifdef TAGGED_DIR_QUEUE_STATS_EN
  logic [NUM_CH-1:0][15:0]      drop_cnt;
  logic [NUM_CH-1:0][CW-1:0]    hwm;
`endif

  tagged_dir_queue_mc #(
    .NUM_CH    (NUM_CH),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_dir      (in_dir),
    .in_ready    (in_ready),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_dir     (out_dir),
    .out_ch      (out_ch),
    .out_ready   (out_ready)
`ifdef TAGGED_DIR_QUEUE_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .hwm         (hwm)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  TaggedDirection mq [NUM_CH][$];
  bit             m_valid;
  TaggedDirection m_dir;
  int             m_ch;
  int             m_lg;
  bit [NUM_CH-1:0] m_ovf;
  int             m_drop [NUM_CH];
  int             m_hwm  [NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_drop[c] = 0;
      m_hwm[c]  = 0;
    end
    m_valid = 1'b0;
    m_dir   = '0;
    m_ch    = 0;
    m_lg    = NUM_CH - 1;
    m_ovf   = '0;
  endfunction

  // One clock edge: the output slot is refilled from the pre-edge queues,
  // then pushes are accepted against pre-edge fullness.
  function automatic void model_step(input logic [NUM_CH-1:0] v,
                                     input TaggedDirection [NUM_CH-1:0] d,
                                     input logic rdy);
    bit [NUM_CH-1:0] ready;
    for (int c = 0; c < NUM_CH; c++) ready[c] = (mq[c].size() < DEPTH);
    if (!m_valid || rdy) begin
      m_valid = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (m_lg + 1 + i) % NUM_CH;
        if (!m_valid && mq[c].size() > 0) begin
          m_dir   = mq[c].pop_front();
          m_ch    = c;
          m_lg    = c;
          m_valid = 1'b1;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      m_ovf[c] = 1'b0;
      if (v[c]) begin
        if (ready[c]) mq[c].push_back(d[c]);
        else begin
          m_ovf[c] = 1'b1;
          if (m_drop[c] < 65535) m_drop[c]++;
        end
      end
      if (mq[c].size() > m_hwm[c]) m_hwm[c] = mq[c].size();
    end
  endfunction

  function automatic TaggedDirection mk(input int tag);
    TaggedDirection t;
    t.dir_x = $urandom;
    t.dir_y = $urandom;
    t.dir_z = $urandom;
    t.tag   = TAG_SIZE'(tag);
    return t;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic [NUM_CH-1:0] v,
                      input TaggedDirection [NUM_CH-1:0] d,
                      input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_dir    = d;
    out_ready = rdy;
    model_step(v, d, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int c, input int tag, input logic rdy);
    logic           [NUM_CH-1:0] v;
    TaggedDirection [NUM_CH-1:0] d;
    v    = '0;
    d    = '0;
    v[c] = 1'b1;
    d[c] = mk(tag);
    step(v, d, rdy);
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, rdy);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = '0;
    in_dir    = '0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (m_valid || mq[0].size() + mq[1].size() +
                                mq[2].size() + mq[3].size() > 0); i++)
      idle(1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_dir !== '0) $display("FAIL reset_out_dir: got %h exp 0", out_dir); else n_pass++;
    n_checks++; if (out_ch !== '0) $display("FAIL reset_out_ch: got %0d exp 0", out_ch); else n_pass++;
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++; if (count[c] !== '0) $display("FAIL reset_count[%0d]: got %0d exp 0", c, count[c]); else n_pass++;
      n_checks++; if (in_ready[c] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %0b exp 1", c, in_ready[c]); else n_pass++;
      n_checks++; if (almost_full[c] !== 1'b0) $display("FAIL reset_almost_full[%0d]: got %0b exp 0", c, almost_full[c]); else n_pass++;
      n_checks++; if (overflow[c] !== 1'b0) $display("FAIL reset_overflow[%0d]: got %0b exp 0", c, overflow[c]); else n_pass++;
`ifdef TAGGED_DIR_QUEUE_STATS_EN
      n_checks++; if (drop_cnt[c] !== '0) $display("FAIL reset_drop_cnt[%0d]: got %0d exp 0", c, drop_cnt[c]); else n_pass++;
      n_checks++; if (hwm[c] !== '0) $display("FAIL reset_hwm[%0d]: got %0d exp 0", c, hwm[c]); else n_pass++;
`endif
    end
  endtask

  task automatic test_ch0_order();
    int tags[$];
    int chs[$];
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) push1(0, k, 1'b1);
      else        idle(1'b1);
      n_checks++; if (out_valid !== m_valid) $display("FAIL ch0_valid step %0d: got %0b exp %0b", k, out_valid, m_valid); else n_pass++;
      if (out_valid) begin
        tags.push_back(int'(out_dir.tag));
        chs.push_back(int'(out_ch));
      end
    end
    n_checks++; if (tags.size() != 3) $display("FAIL ch0_num_out: got %0d exp 3", tags.size()); else n_pass++;
    for (int i = 0; i < 3 && i < tags.size(); i++) begin
      n_checks++; if (tags[i] != i + 1) $display("FAIL ch0_tag[%0d]: got %0d exp %0d", i, tags[i], i + 1); else n_pass++;
      n_checks++; if (chs[i] != 0) $display("FAIL ch0_ch[%0d]: got %0d exp 0", i, chs[i]); else n_pass++;
    end
    n_checks++; if (count[0] !== '0) $display("FAIL ch0_final_count: got %0d exp 0", count[0]); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 40 && mq[1].size() < DEPTH; i++) push1(1, 20 + i, 1'b0);
    n_checks++; if (int'(count[1]) !== DEPTH) $display("FAIL ovf_full_count: got %0d exp %0d", count[1], DEPTH); else n_pass++;
    n_checks++; if (in_ready[1] !== 1'b0) $display("FAIL ovf_in_ready: got %0b exp 0", in_ready[1]); else n_pass++;
    n_checks++; if (almost_full[1] !== 1'b1) $display("FAIL ovf_almost_full: got %0b exp 1", almost_full[1]); else n_pass++;
    push1(1, 99, 1'b0);
    n_checks++; if (overflow[1] !== 1'b1) $display("FAIL ovf_pulse: got %0b exp 1", overflow[1]); else n_pass++;
    n_checks++; if (int'(count[1]) !== DEPTH) $display("FAIL ovf_count_after_drop: got %0d exp %0d", count[1], DEPTH); else n_pass++;
    idle(1'b0);
    n_checks++; if (overflow[1] !== 1'b0) $display("FAIL ovf_pulse_end: got %0b exp 0", overflow[1]); else n_pass++;
    for (int i = 0; i < 40 && (m_valid || mq[1].size() > 0); i++) begin
      idle(1'b1);
      n_checks++; if (out_valid !== m_valid) $display("FAIL ovf_drain_valid: got %0b exp %0b", out_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_checks++; if (out_dir !== m_dir) $display("FAIL ovf_drain_dir: got tag %0d exp tag %0d", out_dir.tag, m_dir.tag); else n_pass++;
        n_checks++; if (out_dir.tag === TAG_SIZE'(99)) $display("FAIL ovf_dropped_seen: got tag %0d exp not 99", out_dir.tag); else n_pass++;
      end
    end
`ifdef TAGGED_DIR_QUEUE_STATS_EN
    n_checks++; if (drop_cnt[1] !== 16'd1) $display("FAIL ovf_drop_cnt: got %0d exp 1", drop_cnt[1]); else n_pass++;
    n_checks++; if (int'(hwm[1]) !== DEPTH) $display("FAIL ovf_hwm: got %0d exp %0d", hwm[1], DEPTH); else n_pass++;
`endif
  endtask

  task automatic test_round_robin();
    TaggedDirection [NUM_CH-1:0] d;
    int chs[$];
    apply_reset();
    for (int r = 1; r <= 2; r++) begin
      for (int c = 0; c < NUM_CH; c++) d[c] = mk(c * 10 + r);
      step('1, d, 1'b0);
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rr_first_valid: got %0b exp 1", out_valid); else n_pass++;
    if (out_valid) chs.push_back(int'(out_ch));
    for (int i = 0; i < 20 && m_valid; i++) begin
      idle(1'b1);
      n_checks++; if (out_valid !== m_valid) $display("FAIL rr_valid: got %0b exp %0b", out_valid, m_valid); else n_pass++;
      if (out_valid) begin
        chs.push_back(int'(out_ch));
        n_checks++; if (out_dir !== m_dir) $display("FAIL rr_dir: got tag %0d exp tag %0d", out_dir.tag, m_dir.tag); else n_pass++;
      end
    end
    n_checks++; if (chs.size() != 8) $display("FAIL rr_num_out: got %0d exp 8", chs.size()); else n_pass++;
    for (int i = 0; i < chs.size() && i < 8; i++) begin
      n_checks++; if (chs[i] != i % NUM_CH) $display("FAIL rr_ch[%0d]: got %0d exp %0d", i, chs[i], i % NUM_CH); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    TaggedDirection [NUM_CH-1:0] d;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NUM_CH; c++) d[c] = mk(40 + r * 4 + c);
      step(4'b0110, d, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid cyc %0d: got %0b exp 1", i, out_valid); else n_pass++;
      n_checks++; if (out_dir !== m_dir) $display("FAIL bp_dir cyc %0d: got tag %0d exp tag %0d", i, out_dir.tag, m_dir.tag); else n_pass++;
      n_checks++; if (int'(out_ch) !== m_ch) $display("FAIL bp_ch cyc %0d: got %0d exp %0d", i, out_ch, m_ch); else n_pass++;
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++; if (int'(count[c]) !== mq[c].size()) $display("FAIL bp_count[%0d] cyc %0d: got %0d exp %0d", c, i, count[c], mq[c].size()); else n_pass++;
      end
    end
    drain();
  endtask

  task automatic test_push_pop();
    int tag = 0;
    apply_reset();
    for (int i = 0; i < 12; i++) begin push1(2, tag, 1'b1); tag++; end
    for (int i = 0; i < 20 && mq[2].size() < 5; i++) begin push1(2, tag, 1'b0); tag++; end
    n_checks++; if (count[2] !== CW'(5)) $display("FAIL pp_start_count: got %0d exp 5", count[2]); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      push1(2, tag, 1'b1);
      tag++;
      n_checks++; if (count[2] !== CW'(5)) $display("FAIL pp_count cyc %0d: got %0d exp 5", i, count[2]); else n_pass++;
      n_checks++; if (out_dir !== m_dir) $display("FAIL pp_dir cyc %0d: got tag %0d exp tag %0d", i, out_dir.tag, m_dir.tag); else n_pass++;
    end
    for (int i = 0; i < 20 && m_valid; i++) begin
      idle(1'b1);
      n_checks++; if (out_valid !== m_valid) $display("FAIL pp_drain_valid: got %0b exp %0b", out_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_checks++; if (out_dir !== m_dir) $display("FAIL pp_drain_dir: got tag %0d exp tag %0d", out_dir.tag, m_dir.tag); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    TaggedDirection [NUM_CH-1:0] d;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NUM_CH; c++) d[c] = mk(60 + r * 4 + c);
      step(4'b1011, d, 1'b0);
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rm_pre_valid: got %0b exp 1", out_valid); else n_pass++;
    @(negedge clk);
    #2;
    reset     = 1'b1;
    in_valid  = '0;
    in_dir    = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_dir !== '0) $display("FAIL rm_out_dir: got %h exp 0", out_dir); else n_pass++;
    n_checks++; if (out_ch !== '0) $display("FAIL rm_out_ch: got %0d exp 0", out_ch); else n_pass++;
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++; if (count[c] !== '0) $display("FAIL rm_count[%0d]: got %0d exp 0", c, count[c]); else n_pass++;
      n_checks++; if (in_ready[c] !== 1'b1) $display("FAIL rm_in_ready[%0d]: got %0b exp 1", c, in_ready[c]); else n_pass++;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push1(3, 77, 1'b1);
    idle(1'b1);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rm_post_valid: got %0b exp 1", out_valid); else n_pass++;
    n_checks++; if (out_ch !== 2'd3) $display("FAIL rm_post_ch: got %0d exp 3", out_ch); else n_pass++;
    n_checks++; if (out_dir.tag !== TAG_SIZE'(77)) $display("FAIL rm_post_tag: got %0d exp 77", out_dir.tag); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    logic           [NUM_CH-1:0] v;
    TaggedDirection [NUM_CH-1:0] d;
    logic                        rdy;
    for (int i = 0; i < 400; i++) begin
      v   = NUM_CH'($urandom);
      rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++) d[c] = mk(int'($urandom_range(0, 255)));
      step(v, d, rdy);
      n_checks++; if (out_valid !== m_valid) $display("FAIL rand_valid cyc %0d: got %0b exp %0b", i, out_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_checks++; if (out_dir !== m_dir) $display("FAIL rand_dir cyc %0d: got %h exp %h", i, out_dir, m_dir); else n_pass++;
        n_checks++; if (int'(out_ch) !== m_ch) $display("FAIL rand_ch cyc %0d: got %0d exp %0d", i, out_ch, m_ch); else n_pass++;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++; if (int'(count[c]) !== mq[c].size()) $display("FAIL rand_count[%0d] cyc %0d: got %0d exp %0d", c, i, count[c], mq[c].size()); else n_pass++;
        n_checks++; if (in_ready[c] !== (mq[c].size() < DEPTH)) $display("FAIL rand_in_ready[%0d] cyc %0d: got %0b", c, i, in_ready[c]); else n_pass++;
        n_checks++; if (almost_full[c] !== (mq[c].size() >= AFULL_LVL)) $display("FAIL rand_almost_full[%0d] cyc %0d: got %0b", c, i, almost_full[c]); else n_pass++;
        n_checks++; if (overflow[c] !== m_ovf[c]) $display("FAIL rand_overflow[%0d] cyc %0d: got %0b exp %0b", c, i, overflow[c], m_ovf[c]); else n_pass++;
      end
    end
`ifdef TAGGED_DIR_QUEUE_STATS_EN
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++; if (int'(drop_cnt[c]) !== m_drop[c]) $display("FAIL rand_drop_cnt[%0d]: got %0d exp %0d", c, drop_cnt[c], m_drop[c]); else n_pass++;
      n_checks++; if (int'(hwm[c]) !== m_hwm[c]) $display("FAIL rand_hwm[%0d]: got %0d exp %0d", c, hwm[c], m_hwm[c]); else n_pass++;
    end
`endif
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_dir    = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_ch0_order();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
